// File: rtl/ysyx_22050710_defs.sv
// Shared encodings for the memory stage: load opcodes, load-wait FSM states
// and the pipeline bus widths.
package ysyx_22050710_defs;

    typedef enum logic [2:0] {
        MEM_OP_LB  = 3'b000,
        MEM_OP_LH  = 3'b001,
        MEM_OP_LW  = 3'b010,
        MEM_OP_LD  = 3'b011,
        MEM_OP_LBU = 3'b100,
        MEM_OP_LHU = 3'b101,
        MEM_OP_LWU = 3'b110
    } mem_op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int ES_TO_MS_BUS_WD_DEF = 216;
    localparam int MS_TO_WS_BUS_WD_DEF = 147;
    localparam int BYPASS_BUS_WD_DEF   = 145;
    localparam int DEBUG_BUS_WD_DEF    = 195;

endpackage

// File: rtl/ysyx_22050710_lsu_load.sv
// Load data alignment: shifts the aligned doubleword down by the byte offset
// and sign- or zero-extends the selected width.
module ysyx_22050710_lsu_load
    import ysyx_22050710_defs::*;
#(
    parameter int WORD_WD      = 64,
    parameter int SRAM_DATA_WD = 64
) (
    input  logic [2:0]              i_mem_op,
    input  logic [2:0]              i_offset,
    input  logic [SRAM_DATA_WD-1:0] i_rdata,
    output logic [WORD_WD-1:0]      o_load_data
);

    logic [SRAM_DATA_WD-1:0] shifted;
    assign shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_load_data = '0;
        case (i_mem_op)
            MEM_OP_LB:  o_load_data = {{(WORD_WD-8){shifted[7]}},   shifted[7:0]};
            MEM_OP_LH:  o_load_data = {{(WORD_WD-16){shifted[15]}}, shifted[15:0]};
            MEM_OP_LW:  o_load_data = {{(WORD_WD-32){shifted[31]}}, shifted[31:0]};
            MEM_OP_LD:  o_load_data = shifted[WORD_WD-1:0];
            MEM_OP_LBU: o_load_data = {{(WORD_WD-8){1'b0}},  shifted[7:0]};
            MEM_OP_LHU: o_load_data = {{(WORD_WD-16){1'b0}}, shifted[15:0]};
            MEM_OP_LWU: o_load_data = {{(WORD_WD-32){1'b0}}, shifted[31:0]};
            default:    o_load_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050710_mem_stage.sv
// Memory stage: latches the execute bus, waits for the data SRAM response of
// loads, and produces the write-back, bypass and load-stall signals.
module ysyx_22050710_mem_stage
    import ysyx_22050710_defs::*;
#(
    parameter int WORD_WD         = 64,
    parameter int PC_WD           = 64,
    parameter int GPR_WD          = 64,
    parameter int GPR_ADDR_WD     = 5,
    parameter int CSR_WD          = 64,
    parameter int CSR_ADDR_WD     = 12,
    parameter int ES_TO_MS_BUS_WD = ES_TO_MS_BUS_WD_DEF,
    parameter int MS_TO_WS_BUS_WD = MS_TO_WS_BUS_WD_DEF,
    parameter int BYPASS_BUS_WD   = BYPASS_BUS_WD_DEF,
    parameter int SRAM_DATA_WD    = 64,
    parameter int DEBUG_BUS_WD    = DEBUG_BUS_WD_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_ws_allowin,
    output logic                       o_ms_allowin,
    input  logic                       i_es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus,
    output logic                       o_ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus,
    input  logic                       i_data_sram_rvalid,
    input  logic [SRAM_DATA_WD-1:0]    i_data_sram_rdata,
    output logic                       o_ms_to_ds_load_stall,
    output logic [BYPASS_BUS_WD-1:0]   o_ms_to_ds_bypass_bus,
    input  logic [DEBUG_BUS_WD-1:0]    i_debug_es_to_ms_bus,
    output logic [DEBUG_BUS_WD-1:0]    o_debug_ms_to_ws_bus
);

    // Position of mem_ren in the incoming bus, needed before it is latched.
    localparam int MEM_REN_BIT = 2 * CSR_WD + WORD_WD + 4;

    logic                       ms_valid_q,  ms_valid_d;
    logic [1:0]                 state_q,     state_d;
    logic [SRAM_DATA_WD-1:0]    rdata_buf_q, rdata_buf_d;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q,    es_bus_d;
    logic [DEBUG_BUS_WD-1:0]    debug_q,     debug_d;

    logic [GPR_ADDR_WD-1:0] rd;
    logic [CSR_ADDR_WD-1:0] csr;
    logic                   gpr_wen;
    logic                   csr_wen;
    logic                   mem_ren;
    logic [2:0]             mem_op;
    logic                   csr_inst_sel;
    logic [CSR_WD-1:0]      csrrdata;
    logic [WORD_WD-1:0]     alu_result;
    logic [CSR_WD-1:0]      csr_result;

    assign {rd, csr, gpr_wen, csr_wen, mem_ren, mem_op, csr_inst_sel,
            csrrdata, alu_result, csr_result} = es_bus_q;

    logic data_ok;
    logic ms_ready_go;
    logic es_accept;
    logic load_enter;

    assign data_ok      = (state_q == ST_WAIT && i_data_sram_rvalid) || (state_q == ST_HOLD);
    assign ms_ready_go  = !mem_ren || data_ok;
    assign o_ms_allowin = !ms_valid_q || (ms_ready_go && i_ws_allowin);
    assign es_accept    = i_es_to_ms_valid && o_ms_allowin;
    assign load_enter   = es_accept && i_es_to_ms_bus[MEM_REN_BIT];

    assign o_ms_to_ws_valid      = ms_valid_q && ms_ready_go;
    assign o_ms_to_ds_load_stall = ms_valid_q && mem_ren && !data_ok;

    always_comb begin
        ms_valid_d  = o_ms_allowin ? i_es_to_ms_valid : ms_valid_q;
        es_bus_d    = es_accept ? i_es_to_ms_bus : es_bus_q;
        debug_d     = es_accept ? i_debug_es_to_ms_bus : debug_q;
        state_d     = state_q;
        rdata_buf_d = rdata_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (load_enter) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_data_sram_rvalid) begin
                    if (i_ws_allowin) begin
                        state_d = load_enter ? ST_WAIT : ST_IDLE;
                    end else begin
                        state_d     = ST_HOLD;
                        rdata_buf_d = i_data_sram_rdata;
                    end
                end
            end
            ST_HOLD: begin
                if (i_ws_allowin) state_d = load_enter ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ms_valid_q  <= 1'b0;
            state_q     <= ST_IDLE;
            rdata_buf_q <= '0;
            es_bus_q    <= '0;
            debug_q     <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
            es_bus_q    <= es_bus_d;
            debug_q     <= debug_d;
        end
    end

    logic [SRAM_DATA_WD-1:0] load_src;
    logic [WORD_WD-1:0]      load_data;
    logic [GPR_WD-1:0]       gpr_wdata;

    assign load_src = (state_q == ST_HOLD) ? rdata_buf_q : i_data_sram_rdata;

    ysyx_22050710_lsu_load #(
        .WORD_WD      (WORD_WD),
        .SRAM_DATA_WD (SRAM_DATA_WD)
    ) u_lsu_load (
        .i_mem_op    (mem_op),
        .i_offset    (alu_result[2:0]),
        .i_rdata     (load_src),
        .o_load_data (load_data)
    );

    assign gpr_wdata = mem_ren ? load_data : csr_inst_sel ? csrrdata : alu_result;

    assign o_ms_to_ws_bus = {rd, gpr_wen, gpr_wdata, csr, csr_wen, csr_result};

    assign o_ms_to_ds_bypass_bus = ms_valid_q ?
        {rd & {GPR_ADDR_WD{gpr_wen}}, gpr_wdata & {GPR_WD{gpr_wen}},
         csr & {CSR_ADDR_WD{csr_wen}}, csr_result & {CSR_WD{csr_wen}}} : '0;

    assign o_debug_ms_to_ws_bus = debug_q;

endmodule

// File: tb/tb_ysyx_22050710_mem_stage.sv
// Directed bench for the memory stage: ALU pass-through, loads with variable
// SRAM latency, back-pressure, CSR read select and reset during a load wait.
module tb_ysyx_22050710_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_valid;
    logic [215:0] es_bus;
    logic         ws_valid;
    logic [146:0] ws_bus;
    logic         rvalid;
    logic [63:0]  rdata;
    logic         load_stall;
    logic [144:0] byp;
    logic [194:0] dbg_in;
    logic [194:0] dbg_out;

    int n_checks = 0;
    int n_fails  = 0;

    ysyx_22050710_mem_stage dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_ws_allowin          (ws_allowin),
        .o_ms_allowin          (ms_allowin),
        .i_es_to_ms_valid      (es_valid),
        .i_es_to_ms_bus        (es_bus),
        .o_ms_to_ws_valid      (ws_valid),
        .o_ms_to_ws_bus        (ws_bus),
        .i_data_sram_rvalid    (rvalid),
        .i_data_sram_rdata     (rdata),
        .o_ms_to_ds_load_stall (load_stall),
        .o_ms_to_ds_bypass_bus (byp),
        .i_debug_es_to_ms_bus  (dbg_in),
        .o_debug_ms_to_ws_bus  (dbg_out)
    );

    wire [63:0] ws_gpr   = ws_bus[140:77];
    wire [4:0]  ws_rd    = ws_bus[146:142];
    wire [4:0]  byp_rd   = byp[144:140];
    wire [63:0] byp_gpr  = byp[139:76];
    wire [11:0] byp_csr  = byp[75:64];
    wire [63:0] byp_cres = byp[63:0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [215:0] mk_bus(
        input logic [4:0] rd, input logic [11:0] csr, input logic gw, input logic cw,
        input logic mr, input logic [2:0] op, input logic sel,
        input logic [63:0] crd, input logic [63:0] alu, input logic [63:0] cres);
        return {rd, csr, gw, cw, mr, op, sel, crd, alu, cres};
    endfunction

    initial begin
        rst = 1'b1; ws_allowin = 1'b1; es_valid = 1'b0; es_bus = '0;
        rvalid = 1'b0; rdata = '0; dbg_in = '0;
        step(); step();
        chk("rst_allowin", {63'b0, ms_allowin}, 64'd1);
        chk("rst_ws_valid", {63'b0, ws_valid}, 64'd0);
        chk("rst_stall", {63'b0, load_stall}, 64'd0);
        chk("rst_bypass", {63'b0, |byp}, 64'd0);
        chk("rst_ws_bus", {63'b0, |ws_bus}, 64'd0);
        chk("rst_debug", {63'b0, |dbg_out}, 64'd0);
        rst = 1'b0;

        // ALU result passes through in one cycle
        es_valid = 1'b1;
        es_bus   = mk_bus(5'd5, 12'h0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'h0, 64'h1234, 64'h0);
        dbg_in   = {3'b101, 64'hDEAD_BEEF_0000_0001, 64'h0, 64'h8000_0000};
        step();
        es_valid = 1'b0;
        dbg_in   = '0;
        #1;
        chk("alu_ws_valid", {63'b0, ws_valid}, 64'd1);
        chk("alu_gpr_wdata", ws_gpr, 64'h1234);
        chk("alu_byp_rd", {59'b0, byp_rd}, 64'd5);
        chk("alu_byp_gpr", byp_gpr, 64'h1234);
        chk("alu_debug", dbg_out[191:128], 64'hDEAD_BEEF_0000_0001);
        step();
        chk("alu_drained", {63'b0, ws_valid}, 64'd0);

        // LB offset 3, rvalid two cycles after entry
        es_valid = 1'b1;
        es_bus   = mk_bus(5'd6, 12'h0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 64'h0, 64'h1003, 64'h0);
        step();
        es_valid = 1'b0;
        #1;
        chk("lb_stall_c1", {63'b0, load_stall}, 64'd1);
        chk("lb_valid_c1", {63'b0, ws_valid}, 64'd0);
        step();
        chk("lb_stall_c2", {63'b0, load_stall}, 64'd1);
        step();
        rvalid = 1'b1;
        rdata  = 64'h00000000_80000000;
        #1;
        chk("lb_valid", {63'b0, ws_valid}, 64'd1);
        chk("lb_gpr_wdata", ws_gpr, 64'hFFFFFFFF_FFFFFF80);
        chk("lb_stall_off", {63'b0, load_stall}, 64'd0);
        chk("lb_byp_gpr", byp_gpr, 64'hFFFFFFFF_FFFFFF80);
        step();
        rvalid = 1'b0;
        #1;
        chk("lb_drained", {63'b0, ws_valid}, 64'd0);
        chk("lb_no_stall", {63'b0, load_stall}, 64'd0);

        // LHU offset 6 under back-pressure -> HOLD
        es_valid = 1'b1;
        es_bus   = mk_bus(5'd8, 12'h0, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 64'h0, 64'h2006, 64'h0);
        step();
        es_valid   = 1'b0;
        ws_allowin = 1'b0;
        rvalid     = 1'b1;
        rdata      = 64'hBEEF0000_00000000;
        #1;
        chk("lhu_valid_rv", {63'b0, ws_valid}, 64'd1);
        chk("lhu_gpr_rv", ws_gpr, 64'h0000_0000_0000_BEEF);
        chk("lhu_allowin_bp", {63'b0, ms_allowin}, 64'd0);
        step();
        rvalid = 1'b0;
        rdata  = 64'h5555_5555_5555_5555;
        #1;
        chk("lhu_hold1_valid", {63'b0, ws_valid}, 64'd1);
        chk("lhu_hold1_gpr", ws_gpr, 64'h0000_0000_0000_BEEF);
        step();
        chk("lhu_hold2_gpr", ws_gpr, 64'h0000_0000_0000_BEEF);
        step();
        ws_allowin = 1'b1;
        #1;
        chk("lhu_release_valid", {63'b0, ws_valid}, 64'd1);
        chk("lhu_release_allowin", {63'b0, ms_allowin}, 64'd1);
        chk("lhu_release_gpr", ws_gpr, 64'h0000_0000_0000_BEEF);
        step();
        chk("lhu_drained", {63'b0, ws_valid}, 64'd0);

        // Back-to-back LW at offsets 0 and 4, minimum SRAM latency
        es_valid = 1'b1;
        es_bus   = mk_bus(5'd9, 12'h0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 64'h0, 64'h3000, 64'h0);
        step();
        es_bus = mk_bus(5'd10, 12'h0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 64'h0, 64'h3004, 64'h0);
        rvalid = 1'b1;
        rdata  = 64'h11111111_FFFFFFFE;
        #1;
        chk("lw0_valid", {63'b0, ws_valid}, 64'd1);
        chk("lw0_gpr", ws_gpr, 64'hFFFFFFFF_FFFFFFFE);
        chk("lw0_allowin", {63'b0, ms_allowin}, 64'd1);
        step();
        es_valid = 1'b0;
        #1;
        chk("lw4_valid", {63'b0, ws_valid}, 64'd1);
        chk("lw4_gpr", ws_gpr, 64'h00000000_11111111);
        chk("lw4_rd", {59'b0, ws_rd}, 64'd10);
        step();
        rvalid = 1'b0;
        #1;
        chk("lw_drained", {63'b0, ws_valid}, 64'd0);
        chk("lw_no_stall", {63'b0, load_stall}, 64'd0);

        // CSR read select, no write enables -> bypass fully masked
        es_valid = 1'b1;
        es_bus   = mk_bus(5'd7, 12'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 64'hABC, 64'h999, 64'h0);
        step();
        es_valid = 1'b0;
        #1;
        chk("csr_ws_valid", {63'b0, ws_valid}, 64'd1);
        chk("csr_gpr_wdata", ws_gpr, 64'hABC);
        chk("csr_byp_masked", {63'b0, |byp}, 64'd0);
        step();

        // CSR write plus GPR write -> both bypass fields visible
        es_valid = 1'b1;
        es_bus   = mk_bus(5'd3, 12'h305, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 64'h0, 64'h42, 64'h77);
        step();
        es_valid = 1'b0;
        #1;
        chk("csrw_byp_csr", {52'b0, byp_csr}, 64'h305);
        chk("csrw_byp_cres", byp_cres, 64'h77);
        chk("csrw_byp_gpr", byp_gpr, 64'h42);
        step();

        // Reset while waiting for a load, then a stale rvalid
        es_valid = 1'b1;
        es_bus   = mk_bus(5'd11, 12'h0, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 64'h0, 64'h4000, 64'h0);
        step();
        es_valid = 1'b0;
        #1;
        chk("rstw_stall", {63'b0, load_stall}, 64'd1);
        rst = 1'b1;
        step();
        rst    = 1'b0;
        rvalid = 1'b1;
        rdata  = 64'h0000_0000_0000_CAFE;
        #1;
        chk("rstw_ws_valid", {63'b0, ws_valid}, 64'd0);
        chk("rstw_stall_off", {63'b0, load_stall}, 64'd0);
        chk("rstw_allowin", {63'b0, ms_allowin}, 64'd1);
        chk("rstw_bypass", {63'b0, |byp}, 64'd0);
        step();
        rvalid = 1'b0;
        #1;
        chk("rstw_after_valid", {63'b0, ws_valid}, 64'd0);
        chk("rstw_after_stall", {63'b0, load_stall}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
